// File: rtl/vga_timing_generator_if.sv
// Raster timing bus between the VGA timing generator and its pixel-fetch/DAC consumers.
// Optional line-compare interrupt signals are present only with VGA_TIMING_LINE_IRQ_EN.
interface vga_timing_generator_if;
   logic        pixel_en;
   logic        hsync;
   logic        vsync;
   logic        display_en;
   logic [10:0] x;
   logic [9:0]  y;
   logic        line_start;
   logic        frame_start;
`ifdef VGA_TIMING_LINE_IRQ_EN
   logic [9:0]  line_cmp;
   logic        irq_ack;
   logic        line_irq;
`endif

`ifdef VGA_TIMING_LINE_IRQ_EN
   modport master (
      input  pixel_en, line_cmp, irq_ack,
      output hsync, vsync, display_en, x, y, line_start, frame_start, line_irq
   );
   modport slave (
      output pixel_en, line_cmp, irq_ack,
      input  hsync, vsync, display_en, x, y, line_start, frame_start, line_irq
   );
`else
   modport master (
      input  pixel_en,
      output hsync, vsync, display_en, x, y, line_start, frame_start
   );
   modport slave (
      output pixel_en,
      input  hsync, vsync, display_en, x, y, line_start, frame_start
   );
`endif
endinterface

// File: rtl/vga_timing_generator.sv
// Raster timing generator: advances pixel/line counters on the pixel strobe and
// produces registered sync, display enable, coordinates and line/frame strobes.
// Optional feature macro: VGA_TIMING_LINE_IRQ_EN (sticky line-compare interrupt).
module vga_timing_generator #(
   parameter int unsigned H_ACTIVE  = 640,
   parameter int unsigned H_FP      = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BP      = 48,
   parameter int unsigned V_ACTIVE  = 480,
   parameter int unsigned V_FP      = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BP      = 33,
   parameter bit          HSYNC_POL = 1'b0,
   parameter bit          VSYNC_POL = 1'b0
) (
   input  logic                   clkin,
   input  logic                   reset,
   vga_timing_generator_if.master bus
);

   localparam int unsigned HW      = 11;
   localparam int unsigned VW      = 10;
   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
   localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
   localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

   logic [HW-1:0] h_cnt, h_nxt;
   logic [VW-1:0] v_cnt, v_nxt;
   logic          line_wrap;
   logic          hsync_nxt, vsync_nxt, de_nxt;
   logic          hsync_q, vsync_q, de_q, line_start_q, frame_start_q;

   // Next counter values; a horizontal wrap also steps the line counter.
   always_comb begin
      h_nxt     = h_cnt;
      v_nxt     = v_cnt;
      line_wrap = 1'b0;
      if (bus.pixel_en) begin
         if (h_cnt == H_LAST) begin
            h_nxt     = '0;
            line_wrap = 1'b1;
            v_nxt     = (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
         end else begin
            h_nxt = h_cnt + HW'(1);
         end
      end
   end

   // Level outputs decoded from the next counter values so they align with x/y.
   always_comb begin
      hsync_nxt = ~HSYNC_POL;
      vsync_nxt = ~VSYNC_POL;
      de_nxt    = 1'b0;
      if (h_nxt >= HS_START && h_nxt < HS_END) hsync_nxt = HSYNC_POL;
      if (v_nxt >= VS_START && v_nxt < VS_END) vsync_nxt = VSYNC_POL;
      if (h_nxt < H_ACT && v_nxt < V_ACT)      de_nxt    = 1'b1;
   end

   // Counter and output registers; strobes are single-cycle by construction.
   always_ff @(posedge clkin) begin
      if (reset) begin
         h_cnt         <= H_LAST;
         v_cnt         <= V_LAST;
         hsync_q       <= ~HSYNC_POL;
         vsync_q       <= ~VSYNC_POL;
         de_q          <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         h_cnt         <= h_nxt;
         v_cnt         <= v_nxt;
         hsync_q       <= hsync_nxt;
         vsync_q       <= vsync_nxt;
         de_q          <= de_nxt;
         line_start_q  <= line_wrap;
         frame_start_q <= line_wrap && (v_nxt == '0);
      end
   end

   assign bus.x           = h_cnt;
   assign bus.y           = v_cnt;
   assign bus.hsync       = hsync_q;
   assign bus.vsync       = vsync_q;
   assign bus.display_en  = de_q;
   assign bus.line_start  = line_start_q;
   assign bus.frame_start = frame_start_q;

`ifdef VGA_TIMING_LINE_IRQ_EN
   logic line_irq_q;
   logic irq_set;

   // Compare against the line being entered; out-of-range compare values never match.
   assign irq_set = line_wrap && (v_nxt == bus.line_cmp);

   // Sticky interrupt flag: a new match takes priority over acknowledge.
   always_ff @(posedge clkin) begin
      if (reset) begin
         line_irq_q <= 1'b0;
      end else if (irq_set) begin
         line_irq_q <= 1'b1;
      end else if (bus.irq_ack) begin
         line_irq_q <= 1'b0;
      end
   end

   assign bus.line_irq = line_irq_q;
`endif

endmodule
